// File: rtl/ether_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ether_bus_ctrl                                                |
// | Purpose  : Buffers decoded Ethernet register requests in a FIFO, issues  |
// |            them one at a time on the core register bus, waits (with a    |
// |            timeout) for read data and hands it to the transmit path.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ether_bus_ctrl #(
  parameter int          DEPTH        = 8,
  parameter int          TIMEOUT      = 64,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  input  logic        req_rw_i,
  input  logic        req_valid_i,
  output logic [15:0] bus_addr_o,
  output logic [15:0] bus_wdata_o,
  output logic        bus_rw_o,
  output logic        bus_valid_o,
  input  logic [15:0] bus_rdata_i,
  input  logic        bus_rvalid_i,
  output logic [15:0] tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        timeout_o,
  input  logic        clear_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] C_TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_RD = 2'd1;
  localparam logic [1:0] S_SEND_RD = 2'd2;

  // Request storage, entry layout {rw, addr, wdata}
  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_drop;
  logic [32:0]   fifo_head;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic          bus_rw_q, bus_rw_d, bus_valid_q, bus_valid_d;
  logic [15:0]   tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          overflow_q, overflow_d, timeout_q, timeout_d;
  logic          timeout_set;

  // FIFO bookkeeping; a push while full is only accepted when a pop frees a slot
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == C_DEPTH);
    fifo_head  = mem_q[rd_ptr_q];
    fifo_pop   = (state_q == S_IDLE) && !fifo_empty;
    fifo_push  = req_valid_i && (!fifo_full || fifo_pop);
    fifo_drop  = req_valid_i && fifo_full && !fifo_pop;
    wr_ptr_d   = fifo_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = fifo_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (fifo_push && !fifo_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!fifo_push && fifo_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Request storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= {req_rw_i, req_addr_i, req_wdata_i};
    end
  end

  // Issue / wait-for-read / hand-to-transmit sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_rw_d    = bus_rw_q;
    bus_valid_d = 1'b0;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          bus_valid_d                         = 1'b1;
          {bus_rw_d, bus_addr_d, bus_wdata_d} = fifo_head;
          if (!fifo_head[32]) begin
            state_d = S_WAIT_RD;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT_RD: begin
        cnt_d = cnt_q + CW'(1);
        // A response in the same cycle as the request strobe cannot be ours
        if (bus_rvalid_i && !bus_valid_q) begin
          tx_data_d = bus_rdata_i;
          state_d   = S_SEND_RD;
        end else if (cnt_q == C_TO_LAST) begin
          tx_data_d   = TIMEOUT_DATA;
          timeout_set = 1'b1;
          state_d     = S_SEND_RD;
        end
      end
      S_SEND_RD: begin
        if (!tx_busy_i) begin
          tx_start_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky error flags; a set event outranks a simultaneous clear
  always_comb begin
    overflow_d = fifo_drop   ? 1'b1 : (clear_i ? 1'b0 : overflow_q);
    timeout_d  = timeout_set ? 1'b1 : (clear_i ? 1'b0 : timeout_q);
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_rw_q    <= 1'b0;
      bus_valid_q <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_rw_q    <= bus_rw_d;
      bus_valid_q <= bus_valid_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_rw_o    = bus_rw_q;
  assign bus_valid_o = bus_valid_q;
  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = tx_start_q;
  assign overflow_o  = overflow_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = !fifo_empty || (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ether_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ether_bus_ctrl                                             |
// | Purpose  : Scoreboard bench for ether_bus_ctrl with a bus responder and  |
// |            a transaction-level expectation of issue order and read data. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ether_bus_ctrl;

  localparam int          DEPTH   = 4;
  localparam int          TIMEOUT = 16;
  localparam logic [15:0] TO_DATA = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_addr_i, req_wdata_i;
  logic        req_rw_i, req_valid_i;
  logic [15:0] bus_addr_o, bus_wdata_o;
  logic        bus_rw_o, bus_valid_o;
  logic [15:0] bus_rdata_i;
  logic        bus_rvalid_i;
  logic [15:0] tx_data_o;
  logic        tx_start_o, tx_busy_i, busy_o, overflow_o, timeout_o, clear_i;

  ether_bus_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TIMEOUT_DATA(TO_DATA)) dut (
    .clk(clk), .rst(rst),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rw_i(req_rw_i), .req_valid_i(req_valid_i),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rw_o(bus_rw_o), .bus_valid_o(bus_valid_o),
    .bus_rdata_i(bus_rdata_i), .bus_rvalid_i(bus_rvalid_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i),
    .busy_o(busy_o), .overflow_o(overflow_o), .timeout_o(timeout_o), .clear_i(clear_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic rw; logic [15:0] addr; logic [15:0] wdata; int at; } bus_item_t;
  typedef struct { logic [15:0] data; int at; } tx_item_t;

  bus_item_t   exp_bus[$];
  tx_item_t    exp_tx[$];
  int          forced_d[$];
  logic [15:0] forced_data[$];
  int          errors = 0, checks = 0, pending = 0;
  bit          timing_mode = 1'b1, saw_timeout = 1'b0, rand_busy = 1'b0;
  int          resp_at = -1;
  logic [15:0] resp_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, expected 0 (cycle %0d)", name, act, cyc);
  endtask

  // Bus responder plus output monitor; both act once per cycle at the falling edge.
  // A read answered d cycles after its strobe is accepted only for 1 <= d <= TIMEOUT-1.
  initial begin
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    forever begin
      @(negedge clk);
      bus_rvalid_i = 1'b0;
      if (resp_at >= 0 && cyc == resp_at) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = resp_data;
        resp_at      = -1;
      end
      if (bus_valid_o) begin
        if (exp_bus.size() == 0) begin
          flag_fail("bus_unexpected_issue", 1);
        end else begin
          bus_item_t e;
          e = exp_bus.pop_front();
          check("bus_fields", {bus_rw_o, bus_addr_o, bus_wdata_o}, {e.rw, e.addr, e.wdata});
          if (e.at >= 0) check("bus_issue_cycle", cyc, e.at);
          pending--;
        end
        if (!bus_rw_o) begin
          int d, r;
          bit acc;
          tx_item_t t;
          if (forced_d.size() != 0) begin
            d         = forced_d.pop_front();
            resp_data = forced_data.pop_front();
          end else begin
            r = $urandom_range(0, 9);
            case (r)
              0:       d = -1;
              1:       d = 0;
              2:       d = TIMEOUT - 1;
              3:       d = TIMEOUT;
              4:       d = TIMEOUT + 1;
              default: d = $urandom_range(1, 6);
            endcase
            resp_data = 16'($urandom);
          end
          acc    = (d >= 1) && (d <= TIMEOUT - 1);
          t.data = acc ? resp_data : TO_DATA;
          t.at   = timing_mode ? (acc ? cyc + d + 2 : cyc + TIMEOUT + 1) : -1;
          if (!acc) saw_timeout = 1'b1;
          exp_tx.push_back(t);
          if (d == 0) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = resp_data;
            resp_at      = -1;
          end else begin
            resp_at = (d > 0) ? cyc + d : -1;
          end
        end
      end
      if (tx_start_o) begin
        if (exp_tx.size() == 0) begin
          flag_fail("tx_unexpected_start", 1);
        end else begin
          tx_item_t t;
          t = exp_tx.pop_front();
          check("tx_data", tx_data_o, t.data);
          if (t.at >= 0) check("tx_start_cycle", cyc, t.at);
        end
      end
    end
  end

  // Random transmit back-pressure during the random phase
  initial begin
    forever begin
      @(negedge clk);
      if (rand_busy) tx_busy_i = ($urandom_range(0, 2) == 0);
    end
  end

  // Drive one request this cycle; at_off >= 0 fixes the expected issue cycle relative to now
  task automatic send(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                      input bit accept, input int at_off);
    @(negedge clk);
    req_rw_i    = rw;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_valid_i = 1'b1;
    if (accept) begin
      bus_item_t e;
      e.rw    = rw;
      e.addr  = addr;
      e.wdata = wdata;
      e.at    = (at_off >= 0) ? cyc + at_off : -1;
      exp_bus.push_back(e);
      pending++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      clear_i     = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0 || busy_o) && n < budget) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_bus.size() + exp_tx.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_rw_i    = 1'b0;
    req_valid_i = 1'b0;
    tx_busy_i   = 1'b0;
    clear_i     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus_addr_o, bus_wdata_o, bus_rw_o, bus_valid_o, tx_data_o,
                            tx_start_o, busy_o, overflow_o, timeout_o}, 64'd0);
    rst = 1'b0;
    idle(2);

    // Single write: issue two cycles after the request
    send(1'b1, 16'h0012, 16'hBEEF, 1'b1, 2);
    idle(5);
    check("write_busy_after", busy_o, 1'b0);

    // Read round trip, response three cycles after the strobe
    forced_d.push_back(3);
    forced_data.push_back(16'h1234);
    send(1'b0, 16'h0005, 16'h0000, 1'b1, 2);
    drain(60);
    idle(3);
    check("read_tx_data_hold", tx_data_o, 16'h1234);
    check("read_no_timeout", timeout_o, 1'b0);

    // Read timeout: tx_start TIMEOUT+1 cycles after the strobe, sticky flag until clear
    forced_d.push_back(-1);
    forced_data.push_back(16'h0000);
    send(1'b0, 16'h0077, 16'h0000, 1'b1, 2);
    drain(80);
    check("timeout_flag_set", timeout_o, 1'b1);
    idle(4);
    check("timeout_flag_sticky", timeout_o, 1'b1);
    check("timeout_tx_data", tx_data_o, TO_DATA);
    @(negedge clk);
    clear_i = 1'b1;
    idle(1);
    check("timeout_flag_cleared", timeout_o, 1'b0);

    // Writes queued behind a slow read issue back-to-back right after tx_start
    forced_d.push_back(10);
    forced_data.push_back(16'hA5A5);
    send(1'b0, 16'h0100, 16'h0000, 1'b1, 2);
    for (int k = 0; k < 4; k++) send(1'b1, 16'h0200 + 16'(k), 16'hC000 + 16'(k), 1'b1, 14);
    idle(1);
    drain(80);

    // Overflow while a read is parked in SEND_RD by transmit back-pressure
    timing_mode = 1'b0;
    @(negedge clk);
    tx_busy_i = 1'b1;
    forced_d.push_back(2);
    forced_data.push_back(16'h5A5A);
    send(1'b0, 16'h0300, 16'h0000, 1'b1, 2);
    idle(4);
    for (int k = 0; k < DEPTH + 2; k++) send(1'b1, 16'h0400 + 16'(k), 16'h1000 + 16'(k), k < DEPTH, -1);
    idle(2);
    check("overflow_flag_set", overflow_o, 1'b1);
    check("overflow_busy", busy_o, 1'b1);
    tx_busy_i = 1'b0;
    drain(80);
    check("overflow_flag_sticky", overflow_o, 1'b1);
    @(negedge clk);
    clear_i = 1'b1;
    idle(1);
    check("overflow_flag_cleared", overflow_o, 1'b0);
    timing_mode = 1'b1;

    // Asynchronous reset while waiting for read data; the late response must be ignored
    forced_d.push_back(6);
    forced_data.push_back(16'h7777);
    send(1'b0, 16'h0500, 16'h0000, 1'b1, 2);
    idle(4);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {bus_addr_o, bus_wdata_o, bus_rw_o, bus_valid_o, tx_data_o,
                                  tx_start_o, busy_o, overflow_o, timeout_o}, 64'd0);
    exp_bus.delete();
    exp_tx.delete();
    pending = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    check("post_reset_tx_data", tx_data_o, 16'h0000);
    check("post_reset_idle", {busy_o, timeout_o}, 2'b00);

    // Randomised traffic; only push when the FIFO provably has room
    timing_mode = 1'b0;
    saw_timeout = 1'b0;
    rand_busy   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int w;
      w = 0;
      while (pending > DEPTH - 1 && w < 500) begin
        @(negedge clk);
        req_valid_i = 1'b0;
        w++;
      end
      if (w >= 500) flag_fail("random_wait_timeout", pending);
      send(($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1, 16'($urandom), 16'($urandom), 1'b1, -1);
      idle($urandom_range(0, 2));
    end
    idle(1);
    drain(3000);
    rand_busy = 1'b0;
    tx_busy_i = 1'b0;
    check("random_timeout_flag", timeout_o, saw_timeout);
    check("random_no_overflow", overflow_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ether_bus_ctrl.md
Name: ether_bus_ctrl

Overview:
Sequences decoded Ethernet register requests onto the shared core register bus. It sits between the Ethernet receive decoder (addr/wdata/rw/valid pulses) and the core bus chain. Incoming requests are buffered in a FIFO and issued one at a time. The controller waits for each read response, with a timeout, and hands read data to the Ethernet transmit path through a start/busy handshake.

Parameters:
DEPTH, 8, request FIFO entries; power of two, minimum 2
TIMEOUT, 64, cycles to wait for a read response before aborting the read
TIMEOUT_DATA, 16'hDEAD, data returned to the transmit path when a read times out

Ports:
clk  in  1  system clock; all logic is clocked on the rising edge
rst  in  1  asynchronous, active-high reset
req_addr_i  in  16  request address from the receive decoder
req_wdata_i  in  16  write data from the receive decoder
req_rw_i  in  1  request type: 1 = write, 0 = read
req_valid_i  in  1  one-cycle request strobe
bus_addr_o  out  16  bus address
bus_wdata_o  out  16  bus write data
bus_rw_o  out  1  bus request type: 1 = write
bus_valid_o  out  1  one-cycle bus request strobe
bus_rdata_i  in  16  read data returned by the bus chain
bus_rvalid_i  in  1  read-data strobe from the bus chain
tx_data_o  out  16  read data for the transmit path
tx_start_o  out  1  one-cycle pulse that starts a transmission
tx_busy_i  in  1  transmit path busy
busy_o  out  1  high when the FIFO is non-empty or state is not IDLE
overflow_o  out  1  sticky flag: a request was dropped because the FIFO was full
timeout_o  out  1  sticky flag: a read timed out
clear_i  in  1  clears overflow_o and timeout_o

Behaviour:
- Reset (async, rst=1): all outputs are 0, the FIFO is empty, state is IDLE and the timeout counter is 0.
- FIFO: entry is {rw, addr, wdata}, 33 bits.
  - Push on req_valid_i when not full.
  - Push while full with no pop in the same cycle: request dropped, overflow_o set.
  - Push and pop in the same cycle while full: push accepted.
  - No bypass path: a push into an empty FIFO is visible to the FSM on the next cycle.
- Bus outputs are registered. bus_valid_o is high for exactly one cycle per issued request. bus_addr_o, bus_wdata_o and bus_rw_o hold their values until the next issue.
- FSM states: IDLE, WAIT_RD, SEND_RD.
  - IDLE, FIFO non-empty: pop the head and drive it on the bus with bus_valid_o=1 in the following cycle.
    - Write: stay in IDLE. Back-to-back writes issue at one per cycle.
    - Read: go to WAIT_RD and clear the counter.
  - WAIT_RD:
    - The counter increments each cycle.
    - bus_rvalid_i=1: latch bus_rdata_i into tx_data_o and go to SEND_RD.
    - Counter reaches TIMEOUT-1 with no rvalid: tx_data_o=TIMEOUT_DATA, set timeout_o, go to SEND_RD.
    - If rvalid and the timeout occur in the same cycle, rvalid wins.
    - The earliest accepted rvalid is in the cycle after bus_valid_o.
  - SEND_RD: while tx_busy_i=1, wait. When tx_busy_i=0, pulse tx_start_o for one cycle and return to IDLE. tx_data_o is held until the next read completes.
- bus_rvalid_i outside WAIT_RD is ignored: no state change and no flag.
- Requests keep entering the FIFO in any state. No new request issues until the FSM returns to IDLE, so at most one read is outstanding.
- Latency, empty FIFO in IDLE:
  - req_valid_i in cycle N gives bus_valid_o in cycle N+2.
  - rvalid in cycle M with tx idle gives tx_start_o in cycle M+2.
- clear_i clears both sticky flags. If clear_i and a new set event occur in the same cycle, the set wins.
- Reset mid-read discards the FIFO and any outstanding read. A response arriving after reset is ignored.

Test Plan:
- Single write: req {rw=1, addr=0x0012, wdata=0xBEEF} in cycle N → bus_valid_o high in cycle N+2 with the same fields; no tx_start_o; busy_o low afterwards.
- Read round trip: read addr=0x0005, bus model returns 0x1234 three cycles after bus_valid_o, tx_busy_i=0 → tx_data_o=0x1234, tx_start_o pulses once two cycles after rvalid.
- Read timeout: read with no rvalid → tx_start_o with tx_data_o=0xDEAD exactly TIMEOUT cycles after entering WAIT_RD plus one cycle; timeout_o=1 until clear_i.
- Queueing under a slow read: a read followed by 4 writes arriving during WAIT_RD → writes issue on consecutive cycles only after tx_start_o; order preserved.
- Overflow: tx_busy_i=1 holds a read in SEND_RD while DEPTH+2 requests are pushed → exactly DEPTH retained, overflow_o=1, the retained requests issue in order once tx_busy_i falls.
- Async reset during WAIT_RD: assert rst mid-cycle → all outputs 0 immediately; a later stray rvalid produces no tx_start_o.
